serial_sub: RTL



---
 rtl/serial_sub.sv | 124 ++++++++++++
 1 files changed

// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor with borrow, LSB-first.
// Captures a, b and bin on an accepted start, produces one difference bit
// per clock for W clocks, then presents the parallel difference and the
// final borrow-out together with a one-cycle done pulse.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous reset, active-high
//   start  - request pulse, accepted when busy=0 (IDLE or DONE)
//   a, b   - minuend / subtrahend, captured on an accepted start
//   bin    - borrow-in, captured on an accepted start
//   busy   - high while shifting
//   sdiff  - current serial difference bit (0 when svalid=0)
//   svalid - qualifies sdiff, high for exactly W cycles per operation
//   done   - one-cycle pulse when diff/bout are updated
//   diff   - a - b - bin mod 2^W, held until the next completion
//   bout   - 1 iff a < b + bin (unsigned)
module serial_sub #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         sdiff,
  output logic         svalid,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         bout
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state, state_n;
  logic [W-1:0]  sa, sa_n;
  logic [W-1:0]  sb, sb_n;
  logic [W-1:0]  res, res_n;
  logic          br, br_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [W-1:0]  diff_n;
  logic          bout_n;
  logic          d;

  always_comb begin
    state_n = state;
    sa_n    = sa;
    sb_n    = sb;
    res_n   = res;
    br_n    = br;
    cnt_n   = cnt;
    diff_n  = diff;
    bout_n  = bout;
    d       = sa[0] ^ sb[0] ^ br;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          sa_n    = a;
          sb_n    = b;
          br_n    = bin;
          cnt_n   = '0;
          state_n = SHIFT;
        end else begin
          state_n = IDLE;
        end
      end
      SHIFT: begin
        br_n  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        sa_n  = {1'b0, sa[W-1:1]};
        sb_n  = {1'b0, sb[W-1:1]};
        res_n = {d, res[W-1:1]};
        cnt_n = cnt + 1'b1;
        if (cnt == LAST) begin
          state_n = DONE;
          // Parallel result is loaded on the edge into DONE so that it is
          // already valid while done is high.
          diff_n  = res_n;
          bout_n  = br_n;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Status outputs are registered from the next-state values so they track
  // the state exactly; sdiff is precomputed from the next operand bits so the
  // bit for the current SHIFT cycle is on the output during that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      busy   <= 1'b0;
      svalid <= 1'b0;
      sdiff  <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      sa     <= sa_n;
      sb     <= sb_n;
      res    <= res_n;
      br     <= br_n;
      cnt    <= cnt_n;
      diff   <= diff_n;
      bout   <= bout_n;
      busy   <= (state_n == SHIFT);
      svalid <= (state_n == SHIFT);
      sdiff  <= (state_n == SHIFT) & (sa_n[0] ^ sb_n[0] ^ br_n);
      done   <= (state_n == DONE);
    end
  end

endmodule
